// File: rtl/branch_stack_if.sv
// -----------------------------------------------------------------------------
// branch_stack_if
// Dispatch / resolution / recovery bundle between the ROB-side control logic
// and the branch checkpoint stack.
//   master : drives the dispatch and resolution inputs and the map-table /
//            free-list snapshot, receives mask, resolved bit, full and
//            recovery data.
//   slave  : the branch_stack itself.
// Signal summary:
//   is_br_i, is_cond_i, is_taken_i    dispatch of a branch (cond/taken are
//                                     informational)
//   br_state_i, br_dep_mask_i         resolution result and the resolving
//                                     branch's dispatch-time mask
//   bak_mp_next_data_i, bak_fl_head_i state to checkpoint at allocation
//   br_mask_o, br_bit_o, full_o       slot occupancy, resolved slot, full flag
//   rc_mt_all_data_o, rc_fl_head_o    recovery snapshot of the resolved slot
// -----------------------------------------------------------------------------
interface branch_stack_if #(
   parameter int BR_MASK_W  = 5,
   parameter int BR_STATE_W = 2,
   parameter int MT_NUM     = 32,
   parameter int PRF_IDX_W  = 6,
   parameter int LRF_IDX_W  = 5
);
   localparam int MT_W = MT_NUM * (PRF_IDX_W + 1);

   logic                  is_br_i;
   logic                  is_cond_i;
   logic                  is_taken_i;
   logic [BR_STATE_W-1:0] br_state_i;
   logic [BR_MASK_W-1:0]  br_dep_mask_i;
   logic [MT_W-1:0]       bak_mp_next_data_i;
   logic [LRF_IDX_W-1:0]  bak_fl_head_i;
   logic [BR_MASK_W-1:0]  br_mask_o;
   logic [BR_MASK_W-1:0]  br_bit_o;
   logic                  full_o;
   logic [MT_W-1:0]       rc_mt_all_data_o;
   logic [LRF_IDX_W-1:0]  rc_fl_head_o;

   modport master (
      output is_br_i, is_cond_i, is_taken_i, br_state_i, br_dep_mask_i,
             bak_mp_next_data_i, bak_fl_head_i,
      input  br_mask_o, br_bit_o, full_o, rc_mt_all_data_o, rc_fl_head_o
   );

   modport slave (
      input  is_br_i, is_cond_i, is_taken_i, br_state_i, br_dep_mask_i,
             bak_mp_next_data_i, bak_fl_head_i,
      output br_mask_o, br_bit_o, full_o, rc_mt_all_data_o, rc_fl_head_o
   );
endinterface

// File: rtl/branch_stack.sv
// -----------------------------------------------------------------------------
// branch_stack
// Branch checkpoint stack with BR_MASK_W slots. A dispatched branch takes the
// lowest free slot, records the mask of older branches as its tag and
// snapshots the map table and free-list head. A resolution finds its slot by
// tag; a correct prediction frees just that slot, a misprediction frees it and
// every slot allocated after it, and the snapshot is presented for recovery.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bs   : branch_stack_if.slave (dispatch, resolution, snapshot, recovery)
// -----------------------------------------------------------------------------
module branch_stack #(
   parameter int BR_MASK_W  = 5,
   parameter int BR_STATE_W = 2,
   parameter int MT_NUM     = 32,
   parameter int PRF_IDX_W  = 6,
   parameter int LRF_IDX_W  = 5
) (
   input  logic            clk,
   input  logic            rst,
   branch_stack_if.slave   bs
);
   localparam int MT_W = MT_NUM * (PRF_IDX_W + 1);
   localparam logic [BR_STATE_W-1:0] ST_CORRECT = BR_STATE_W'(1);
   localparam logic [BR_STATE_W-1:0] ST_WRONG   = BR_STATE_W'(2);

   // One-hot of the lowest clear bit of v (0 when v is all ones).
   function automatic logic [BR_MASK_W-1:0] lowest_zero(input logic [BR_MASK_W-1:0] v);
      return ~v & (v + BR_MASK_W'(1));
   endfunction

   logic [BR_MASK_W-1:0] valid_r;
   logic [BR_MASK_W-1:0] tag_r     [BR_MASK_W];
   logic [BR_MASK_W-1:0] younger_r [BR_MASK_W];
   logic [MT_W-1:0]      mt_snap_r [BR_MASK_W];
   logic [LRF_IDX_W-1:0] fl_snap_r [BR_MASK_W];

   logic                 full_s;
   logic                 state_active_s;
   logic                 is_wrong_s;
   logic [BR_MASK_W-1:0] res_oh_s;
   logic [BR_MASK_W-1:0] res_young_s;
   logic [BR_MASK_W-1:0] kill_s;
   logic [BR_MASK_W-1:0] survivors_s;
   logic                 alloc_en_s;
   logic [BR_MASK_W-1:0] alloc_oh_s;
   logic [BR_MASK_W-1:0] valid_next_s;
   logic [BR_MASK_W-1:0] younger_next_s [BR_MASK_W];
   logic [MT_W-1:0]      rc_mt_s;
   logic [LRF_IDX_W-1:0] rc_fl_s;
   logic                 unused_info_s;

   // Branch direction hints are carried on the bus but play no part here.
   assign unused_info_s = bs.is_cond_i ^ bs.is_taken_i;

   assign full_s         = &valid_r;
   assign state_active_s = (bs.br_state_i == ST_CORRECT) || (bs.br_state_i == ST_WRONG);
   assign is_wrong_s     = (bs.br_state_i == ST_WRONG);

   // Tag match of the resolving branch; tags of live slots are unique, so at
   // most one bit is set. Also gathers the matched slot's younger set and
   // recovery snapshot as an AND-OR mux.
   always_comb begin
      res_oh_s    = '0;
      res_young_s = '0;
      rc_mt_s     = '0;
      rc_fl_s     = '0;
      for (int k = 0; k < BR_MASK_W; k++) begin
         res_oh_s[k] = valid_r[k] && (tag_r[k] == bs.br_dep_mask_i) && state_active_s;
      end
      for (int k = 0; k < BR_MASK_W; k++) begin
         res_young_s = res_young_s | (younger_r[k] & {BR_MASK_W{res_oh_s[k]}});
         rc_mt_s     = rc_mt_s     | (mt_snap_r[k] & {MT_W{res_oh_s[k]}});
         rc_fl_s     = rc_fl_s     | (fl_snap_r[k] & {LRF_IDX_W{res_oh_s[k]}});
      end
   end

   // Next occupancy and younger vectors. The new slot is picked from the
   // pre-edge mask so a slot freed this cycle is not reused until next cycle,
   // and only surviving older slots record it as younger.
   always_comb begin
      kill_s       = res_oh_s | (is_wrong_s ? res_young_s : BR_MASK_W'(0));
      survivors_s  = valid_r & ~kill_s;
      alloc_en_s   = bs.is_br_i && !full_s && !(is_wrong_s && (|res_oh_s));
      alloc_oh_s   = alloc_en_s ? lowest_zero(valid_r) : BR_MASK_W'(0);
      valid_next_s = survivors_s | alloc_oh_s;
      for (int j = 0; j < BR_MASK_W; j++) begin
         younger_next_s[j] = (kill_s[j] || alloc_oh_s[j]) ? BR_MASK_W'(0) :
                             ((younger_r[j] & ~kill_s) |
                              (survivors_s[j] ? alloc_oh_s : BR_MASK_W'(0)));
      end
   end

   // Slot state registers; tags and snapshots only load on allocation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_r <= '0;
         for (int k = 0; k < BR_MASK_W; k++) begin
            tag_r[k]     <= '0;
            younger_r[k] <= '0;
            mt_snap_r[k] <= '0;
            fl_snap_r[k] <= '0;
         end
      end else begin
         valid_r <= valid_next_s;
         for (int k = 0; k < BR_MASK_W; k++) begin
            younger_r[k] <= younger_next_s[k];
            if (alloc_oh_s[k]) begin
               tag_r[k]     <= valid_r;
               mt_snap_r[k] <= bs.bak_mp_next_data_i;
               fl_snap_r[k] <= bs.bak_fl_head_i;
            end
         end
      end
   end

   assign bs.br_mask_o        = valid_r;
   assign bs.full_o           = full_s;
   assign bs.br_bit_o         = res_oh_s;
   assign bs.rc_mt_all_data_o = rc_mt_s;
   assign bs.rc_fl_head_o     = rc_fl_s;

endmodule

// File: tb/tb_branch_stack.sv
// -----------------------------------------------------------------------------
// tb_branch_stack
// Directed stimulus against branch_stack. A model of live branches (slot, tag,
// allocation order, snapshot) predicts every output on each falling edge;
// hand-computed masks and resolved bits from the stimulus pin the model.
// -----------------------------------------------------------------------------
module tb_branch_stack;
   localparam int W    = 5;
   localparam int MT_W = 32 * 7;
   localparam int FL_W = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_stack_if bif();
   branch_stack dut (.clk(clk), .rst(rst), .bs(bif.slave));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [MT_W-1:0] act, input logic [MT_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- snapshot pattern: bumps once per cycle -----------------
   logic [31:0] snap_cnt;
   initial begin
      snap_cnt = 32'd0;
      bif.bak_mp_next_data_i = {7{snap_cnt}};
      bif.bak_fl_head_i      = snap_cnt[FL_W-1:0];
      forever begin
         @(posedge clk);
         #1;
         snap_cnt = snap_cnt + 32'd1;
         bif.bak_mp_next_data_i = {7{snap_cnt}};
         bif.bak_fl_head_i      = snap_cnt[FL_W-1:0];
      end
   end

   // ---------------- model: live branches with allocation order -------------
   bit              m_valid [W];
   logic [W-1:0]    m_tag   [W];
   int              m_seq   [W];
   logic [MT_W-1:0] m_mt    [W];
   logic [FL_W-1:0] m_fl    [W];
   int              m_next_seq = 0;

   function automatic logic [W-1:0] m_mask();
      logic [W-1:0] v;
      for (int k = 0; k < W; k++) v[k] = m_valid[k];
      return v;
   endfunction

   function automatic int find_r(input logic [1:0] st, input logic [W-1:0] dep);
      if (st != 2'd1 && st != 2'd2) return -1;
      for (int k = 0; k < W; k++)
         if (m_valid[k] && m_tag[k] == dep) return k;
      return -1;
   endfunction

   int   mr;
   int   mk;
   bit   mnv [W];
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < W; k++) begin
            m_valid[k] <= 1'b0;
            m_tag[k]   <= '0;
            m_seq[k]   <= 0;
            m_mt[k]    <= '0;
            m_fl[k]    <= '0;
         end
      end else begin
         mr = find_r(bif.br_state_i, bif.br_dep_mask_i);
         for (int k = 0; k < W; k++) mnv[k] = m_valid[k];
         if (mr >= 0) begin
            for (int k = 0; k < W; k++)
               if (m_valid[k] && (k == mr || (bif.br_state_i == 2'd2 && m_seq[k] > m_seq[mr])))
                  mnv[k] = 1'b0;
         end
         mk = -1;
         if (bif.is_br_i && m_mask() != 5'b11111 && !(mr >= 0 && bif.br_state_i == 2'd2)) begin
            for (int k = W - 1; k >= 0; k--) if (!m_valid[k]) mk = k;
         end
         if (mk >= 0) begin
            mnv[mk]     = 1'b1;
            m_tag[mk]  <= m_mask();
            m_seq[mk]  <= m_next_seq;
            m_mt[mk]   <= bif.bak_mp_next_data_i;
            m_fl[mk]   <= bif.bak_fl_head_i;
            m_next_seq <= m_next_seq + 1;
         end
         for (int k = 0; k < W; k++) m_valid[k] <= mnv[k];
      end
   end

   // ---------------- compare process: every falling edge --------------------
   int cr;
   always @(negedge clk) begin
      cr = find_r(bif.br_state_i, bif.br_dep_mask_i);
      check("model_mask", bif.br_mask_o, m_mask());
      check("model_full", bif.full_o, (m_mask() == 5'b11111) ? 1 : 0);
      check("model_bit", bif.br_bit_o, (cr >= 0) ? (5'd1 << cr) : 5'd0);
      check("model_rc_mt", bif.rc_mt_all_data_o, (cr >= 0) ? m_mt[cr] : '0);
      check("model_rc_fl", bif.rc_fl_head_o, (cr >= 0) ? m_fl[cr] : '0);
   end

   // ---------------- stimulus -----------------------------------------------
   logic [W-1:0]    inc_bit;
   logic [MT_W-1:0] inc_mt;
   logic [FL_W-1:0] inc_fl;
   logic [MT_W-1:0] cap_mt;
   logic [FL_W-1:0] cap_fl;
   logic [MT_W-1:0] slot1_mt;
   logic [FL_W-1:0] slot1_fl;
   logic [W-1:0]    fill_exp [5];

   // Drive one cycle; in-cycle outputs are captured before the edge, the task
   // returns 4ns after the edge.
   task automatic apply(input logic b, input logic [1:0] st, input logic [W-1:0] dep);
      bif.is_br_i       = b;
      bif.is_cond_i     = b;
      bif.is_taken_i    = 1'b0;
      bif.br_state_i    = st;
      bif.br_dep_mask_i = dep;
      #2;
      inc_bit = bif.br_bit_o;
      inc_mt  = bif.rc_mt_all_data_o;
      inc_fl  = bif.rc_fl_head_o;
      cap_mt  = bif.bak_mp_next_data_i;
      cap_fl  = bif.bak_fl_head_i;
      @(posedge clk);
      #4;
   endtask

   initial begin
      fill_exp[0] = 5'b00001; fill_exp[1] = 5'b00011; fill_exp[2] = 5'b00111;
      fill_exp[3] = 5'b01111; fill_exp[4] = 5'b11111;
      rst = 1'b0;
      bif.is_br_i = 1'b0; bif.is_cond_i = 1'b0; bif.is_taken_i = 1'b0;
      bif.br_state_i = 2'd0; bif.br_dep_mask_i = 5'd0;
      #12;
      check("rst_mask", bif.br_mask_o, 5'b00000);
      check("rst_full", bif.full_o, 1'b0);
      check("rst_bit", bif.br_bit_o, 5'b00000);
      check("rst_rc_mt", bif.rc_mt_all_data_o, '0);
      check("rst_rc_fl", bif.rc_fl_head_o, 5'd0);
      rst = 1'b1;
      @(posedge clk);
      #4;

      // fill all five slots
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 2'd0, 5'd0);
         if (i == 1) begin
            slot1_mt = cap_mt;
            slot1_fl = cap_fl;
         end
         check("fill_mask", bif.br_mask_o, fill_exp[i]);
         check("fill_full", bif.full_o, (i == 4) ? 1'b1 : 1'b0);
         check("fill_bit", inc_bit, 5'b00000);
         check("fill_rc_fl", inc_fl, 5'd0);
      end

      // correct resolutions
      apply(1'b0, 2'd1, 5'b00011);
      check("corr1_bit", inc_bit, 5'b00100);
      check("corr1_mask", bif.br_mask_o, 5'b11011);
      apply(1'b0, 2'd1, 5'b01111);
      check("corr2_bit", inc_bit, 5'b10000);
      check("corr2_mask", bif.br_mask_o, 5'b01011);
      check("corr2_full", bif.full_o, 1'b0);

      // wrong resolution of slot 1 squashes slot 3
      apply(1'b0, 2'd2, 5'b00001);
      check("wrong_bit", inc_bit, 5'b00010);
      check("wrong_rc_mt", inc_mt, slot1_mt);
      check("wrong_rc_fl", inc_fl, slot1_fl);
      check("wrong_mask", bif.br_mask_o, 5'b00001);

      // refill
      for (int i = 1; i < 5; i++) begin
         apply(1'b1, 2'd0, 5'd0);
         check("refill_mask", bif.br_mask_o, fill_exp[i]);
         check("refill_full", bif.full_o, (i == 4) ? 1'b1 : 1'b0);
      end

      // dispatch while full is ignored
      apply(1'b1, 2'd0, 5'd0);
      check("stall_mask", bif.br_mask_o, 5'b11111);

      // free slot 4, then dispatch together with a correct resolution of slot 2
      apply(1'b0, 2'd1, 5'b01111);
      check("free4_mask", bif.br_mask_o, 5'b01111);
      apply(1'b1, 2'd1, 5'b00011);
      check("conc_corr_bit", inc_bit, 5'b00100);
      check("conc_corr_mask", bif.br_mask_o, 5'b11011);

      // dispatch with a wrong resolution of slot 3: slot 4 squashed, dispatch dropped
      apply(1'b1, 2'd2, 5'b00111);
      check("conc_wrong_bit", inc_bit, 5'b01000);
      check("conc_wrong_mask", bif.br_mask_o, 5'b00011);

      // wrong resolution of the oldest branch empties the stack
      apply(1'b0, 2'd2, 5'b00000);
      check("flush_bit", inc_bit, 5'b00001);
      check("flush_mask", bif.br_mask_o, 5'b00000);

      apply(1'b1, 2'd0, 5'd0);
      apply(1'b1, 2'd0, 5'd0);
      check("re2_mask", bif.br_mask_o, 5'b00011);

      // no tag match and state 3 both leave everything alone
      apply(1'b0, 2'd1, 5'b10101);
      check("nomatch_bit", inc_bit, 5'b00000);
      check("nomatch_mask", bif.br_mask_o, 5'b00011);
      apply(1'b0, 2'd3, 5'b00001);
      check("st3_bit", inc_bit, 5'b00000);
      check("st3_mask", bif.br_mask_o, 5'b00011);

      // asynchronous reset mid-cycle
      apply(1'b0, 2'd0, 5'd0);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_mask", bif.br_mask_o, 5'b00000);
      check("async_rst_full", bif.full_o, 1'b0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #4;
      apply(1'b1, 2'd0, 5'd0);
      check("post_rst_mask", bif.br_mask_o, 5'b00001);
      apply(1'b0, 2'd0, 5'd0);
      apply(1'b0, 2'd0, 5'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
